fifo_naranja: RTL and testbench

// - Input-side (naranja) FIFO feeding one input lane of the 4-lane arbiter: stores words from the

---
 rtl/fifo_naranja.sv | 99 +++++++++
 tb/tb_fifo_naranja.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_naranja.sv
// Synchronous FIFO with sticky error and threshold flags; feeds one arbiter lane.
// Define FIFO_FWFT_EN for first-word-fall-through reads (default: 1-cycle registered read).
module fifo_naranja #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_almost_full,
  input  logic [ADDR_WIDTH:0]   umbral_almost_empty,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic                  do_push, do_pop;

  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_COUNT);
  assign almost_full  = (count_q >= umbral_almost_full);
  assign almost_empty = (count_q <= umbral_almost_empty);
  assign fifo_count   = count_q;
  assign error        = error_q;

  always_comb begin
    do_pop  = pop && !empty;
    // A pop on a full FIFO frees the slot this push lands in.
    do_push = push && (!full || do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;

    if ((push && !do_push) || (pop && !do_pop)) error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out  = mem[rd_ptr_q];
  assign valid_out = !empty;
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= do_pop;
      if (do_pop) data_q <= mem[rd_ptr_q];
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
`endif

endmodule

// File: tb/tb_fifo_naranja.sv
// Directed bench for fifo_naranja in its default registered-read build.
module tb_fifo_naranja;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop;
  logic [5:0] data_in;
  logic [2:0] umbral_almost_full, umbral_almost_empty;
  logic [5:0] data_out;
  logic       valid_out, empty, full, almost_full, almost_empty, error;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  fifo_naranja #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .push                (push),
    .data_in             (data_in),
    .pop                 (pop),
    .umbral_almost_full  (umbral_almost_full),
    .umbral_almost_empty (umbral_almost_empty),
    .data_out            (data_out),
    .valid_out           (valid_out),
    .empty               (empty),
    .full                (full),
    .almost_full         (almost_full),
    .almost_empty        (almost_empty),
    .fifo_count          (fifo_count),
    .error               (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_almost_full = 3'd3; umbral_almost_empty = 3'd1;
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_error", error, 0);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    step();
    reset = 1'b0;

    // Fill with 1..4
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; data_in = 6'(i);
      step();
      check("fill_count", fifo_count, i);
      check("fill_af", almost_full, (i >= 3) ? 1 : 0);
      check("fill_full", full, (i == 4) ? 1 : 0);
      check("fill_err", error, 0);
    end
    check("fill_ae", almost_empty, 0);

    // Push while full is dropped
    data_in = 6'h05;
    step();
    push = 1'b0;
    check("ovf_count", fifo_count, 4);
    check("ovf_err", error, 1);

    for (int i = 1; i <= 4; i++) begin
      pop = 1'b1;
      step();
      check("drain_valid", valid_out, 1);
      check("drain_data", data_out, i);
    end
    pop = 1'b0;
    check("drain_empty", empty, 1);
    step();
    check("idle_valid", valid_out, 0);
    check("idle_data_hold", data_out, 6'h04);

    // Pointer wrap with simultaneous push+pop at count 2
    pulse_reset();
    check("rst2_err", error, 0);
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; data_in = 6'(8'h10 + i);
      step();
    end
    push = 1'b0; pop = 1'b1;
    step();
    check("wrap_pre_data", data_out, 6'h10);
    check("wrap_pre_count", fifo_count, 2);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; pop = 1'b1; data_in = 6'(8'h13 + i);
      step();
      check("pp_count", fifo_count, 2);
      check("pp_data", data_out, 6'(8'h11 + i));
      check("pp_valid", valid_out, 1);
    end
    push = 1'b0;
    step();
    check("wrap_tail0", data_out, 6'h15);
    step();
    check("wrap_tail1", data_out, 6'h16);
    check("wrap_empty", empty, 1);
    pop = 1'b0;
    check("wrap_err", error, 0);

    // Push+pop while full: both happen, no error
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; data_in = 6'(8'h20 + i);
      step();
    end
    check("full2", full, 1);
    data_in = 6'h24; pop = 1'b1;
    step();
    check("fullpp_count", fifo_count, 4);
    check("fullpp_data", data_out, 6'h20);
    check("fullpp_err", error, 0);
    push = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("fulldrain_data", data_out, 6'(8'h20 + i));
    end
    pop = 1'b0;
    check("fulldrain_empty", empty, 1);

    // Pop on empty
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("uf_err", error, 1);
    check("uf_valid", valid_out, 0);
    check("uf_data_hold", data_out, 6'h24);
    check("uf_count", fifo_count, 0);

    // Push+pop on empty: push lands, pop flagged
    pulse_reset();
    push = 1'b1; pop = 1'b1; data_in = 6'h30;
    step();
    pop = 1'b0;
    check("epp_count", fifo_count, 1);
    check("epp_err", error, 1);
    check("epp_valid", valid_out, 0);

    // Async reset mid-stream with count 3 and push active
    data_in = 6'h31;
    step();
    data_in = 6'h32;
    step();
    check("mid_count", fifo_count, 3);
    data_in = 6'h33;
    reset = 1'b1;
    #1;
    check("arst_count", fifo_count, 0);
    check("arst_empty", empty, 1);
    check("arst_err", error, 0);
    check("arst_valid", valid_out, 0);
    #1;
    reset = 1'b0; push = 1'b0;
    step();
    check("post_rst_count", fifo_count, 0);
    push = 1'b1; data_in = 6'h3A;
    step();
    push = 1'b0; pop = 1'b1;
    step();
    pop = 1'b0;
    check("post_rst_data", data_out, 6'h3A);
    check("post_rst_empty", empty, 1);

    // Thresholds act combinationally
    umbral_almost_full = 3'd0;
    #1;
    check("thr_af0", almost_full, 1);
    umbral_almost_empty = 3'd0;
    #1;
    check("thr_ae0", almost_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
